// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//
// Instruction fetch stage with a decoupling queue. It holds the fetch PC,
// drives a combinational-read instruction memory, and buffers fetched
// {pc, inst, pc+INC} entries in a DEPTH-entry circular queue. Decode drains
// the queue through a valid/ready handshake. A redirect supplies this
// cycle's fetch address and flushes everything decode has not taken.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   enable        : allow a fetch this cycle
//   redirect      : fetch from redirect_pc this cycle and flush the queue
//   redirect_pc   : redirect target
//   imem_addr     : instruction memory address (combinational)
//   imem_req      : a fetch is performed this cycle
//   imem_rdata    : instruction memory data, valid in the same cycle
//   out_valid     : queue head valid
//   out_ready     : decode accepts the head
//   out_pc        : head entry PC
//   out_inst      : head entry instruction
//   out_incpc     : head entry PC + INC
//   count         : number of occupied entries
// ---------------------------------------------------------------------------
module ifetch_queue #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter int                 INC      = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  localparam int                CNT_W    = $clog2(DEPTH + 1),
  localparam int                PTR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_incpc,
  output logic [CNT_W-1:0]  count
);

  localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [ADDR_W-1:0] fetchPc;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [CNT_W-1:0]  countQ;

  logic [ADDR_W-1:0] pcMem   [DEPTH];
  logic [INST_W-1:0] instMem [DEPTH];
  logic [ADDR_W-1:0] incMem  [DEPTH];

  logic              full;
  logic              deq;
  logic              fetch;
  logic [ADDR_W-1:0] nextAddr;
  logic [PTR_W-1:0]  wrIdx;

  // Redirect bypasses the PC register so the target is fetched this cycle.
  assign imem_addr = redirect ? redirect_pc : fetchPc;
  assign nextAddr  = imem_addr + INC_V;

  assign out_valid = (countQ != '0);
  assign deq       = out_valid & out_ready;
  assign full      = (countQ == CNT_W'(DEPTH));
  // A full queue can still accept a fetch when the head leaves this cycle,
  // and a redirect always frees space because it flushes the queue.
  assign fetch     = enable & (redirect | ~full | deq);
  assign imem_req  = fetch & ~rst;

  // A flush restarts the queue at slot 0, so a redirect fetch lands there.
  assign wrIdx     = redirect ? '0 : wrPtr;

  assign count     = countQ;
  assign out_pc    = pcMem[rdPtr];
  assign out_inst  = instMem[rdPtr];
  assign out_incpc = incMem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc <= RESET_PC;
      rdPtr   <= '0;
      wrPtr   <= '0;
      countQ  <= '0;
    end else if (redirect) begin
      rdPtr <= '0;
      if (fetch) begin
        wrPtr   <= nextPtr('0);
        countQ  <= CNT_W'(1);
        fetchPc <= nextAddr;
      end else begin
        wrPtr   <= '0;
        countQ  <= '0;
        fetchPc <= redirect_pc;
      end
    end else begin
      if (fetch) begin
        wrPtr   <= nextPtr(wrPtr);
        fetchPc <= nextAddr;
      end
      if (deq) begin
        rdPtr <= nextPtr(rdPtr);
      end
      countQ <= countQ + CNT_W'(fetch) - CNT_W'(deq);
    end
  end

  // Entry storage carries no reset; occupancy is tracked by countQ alone.
  always_ff @(posedge clk) begin
    if (imem_req) begin
      pcMem[wrIdx]   <= imem_addr;
      instMem[wrIdx] <= imem_rdata;
      incMem[wrIdx]  <= nextAddr;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst, enable, redirect, out_ready;
  logic [31:0] redirect_pc;

  logic [31:0] addr1, rdata1, pc1, inst1, inc1;
  logic        req1, vld1;
  logic [2:0]  cnt1;

  logic [31:0] addr2, rdata2, pc2, inst2, inc2;
  logic        req2, vld2;
  logic [1:0]  cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rdata1 = addr1 ^ 32'h0000_FFFF;
  assign rdata2 = addr2 ^ 32'h0000_FFFF;

  ifetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .INC(4),
                 .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .enable(enable), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(addr1), .imem_req(req1),
    .imem_rdata(rdata1), .out_valid(vld1), .out_ready(out_ready),
    .out_pc(pc1), .out_inst(inst1), .out_incpc(inc1), .count(cnt1)
  );

  ifetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(3), .INC(4),
                 .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(addr2), .imem_req(req2),
    .imem_rdata(rdata2), .out_valid(vld2), .out_ready(out_ready),
    .out_pc(pc2), .out_inst(inst2), .out_incpc(inc2), .count(cnt2)
  );

  typedef struct packed {
    logic        rst, en, redir;
    logic [31:0] rpc;
    logic        rdy, chk;
    logic [31:0] addr;
    logic        req, vld;
    logic [31:0] pc, inst, incpc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic rd, logic [31:0] rp,
                              logic rdy, logic c, logic [31:0] a, logic q,
                              logic v, logic [31:0] p, logic [31:0] i,
                              logic [31:0] ip, logic [2:0] n);
    vec_t t;
    t.rst = r; t.en = e; t.redir = rd; t.rpc = rp; t.rdy = rdy; t.chk = c;
    t.addr = a; t.req = q; t.vld = v; t.pc = p; t.inst = i; t.incpc = ip;
    t.cnt = n;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; redirect = 1'b0; out_ready = 1'b0;
    redirect_pc = '0;
    #1;

    // rst en redir rpc rdy chk | addr req vld pc inst incpc cnt
    vecs.push_back(mk(1,0,0,0,     1,0, 0,     0,0, 0,     0,       0,     0));
    vecs.push_back(mk(0,0,0,0,     1,1, 0,     0,0, 0,     0,       0,     0));
    // streaming with decode always ready
    vecs.push_back(mk(0,1,0,0,     1,1, 0,     1,0, 0,     0,       0,     0));
    vecs.push_back(mk(0,1,0,0,     1,1, 'h4,   1,1, 'h0,   'hFFFF,  'h4,   1));
    vecs.push_back(mk(0,1,0,0,     1,1, 'h8,   1,1, 'h4,   'hFFFB,  'h8,   1));
    vecs.push_back(mk(0,1,0,0,     1,1, 'hC,   1,1, 'h8,   'hFFF7,  'hC,   1));
    // reset blocks the request even with enable high
    vecs.push_back(mk(1,1,0,0,     1,1, 'h10,  0,1, 'hC,   'hFFF3,  'h10,  1));
    // fill with decode stalled
    vecs.push_back(mk(0,1,0,0,     0,1, 0,     1,0, 0,     0,       0,     0));
    vecs.push_back(mk(0,1,0,0,     0,1, 'h4,   1,1, 'h0,   'hFFFF,  'h4,   1));
    vecs.push_back(mk(0,1,0,0,     0,1, 'h8,   1,1, 'h0,   'hFFFF,  'h4,   2));
    vecs.push_back(mk(0,1,0,0,     0,1, 'hC,   1,1, 'h0,   'hFFFF,  'h4,   3));
    vecs.push_back(mk(0,1,0,0,     0,1, 'h10,  0,1, 'h0,   'hFFFF,  'h4,   4));
    vecs.push_back(mk(0,1,0,0,     0,1, 'h10,  0,1, 'h0,   'hFFFF,  'h4,   4));
    // drain while full: push and pop together
    vecs.push_back(mk(0,1,0,0,     1,1, 'h10,  1,1, 'h0,   'hFFFF,  'h4,   4));
    vecs.push_back(mk(0,1,0,0,     1,1, 'h14,  1,1, 'h4,   'hFFFB,  'h8,   4));
    vecs.push_back(mk(0,1,0,0,     1,1, 'h18,  1,1, 'h8,   'hFFF7,  'hC,   4));
    vecs.push_back(mk(0,1,0,0,     1,1, 'h1C,  1,1, 'hC,   'hFFF3,  'h10,  4));
    vecs.push_back(mk(0,1,0,0,     1,1, 'h20,  1,1, 'h10,  'hFFEF,  'h14,  4));
    // redirect on a full queue, head accepted the same cycle
    vecs.push_back(mk(0,1,1,'h100, 1,1, 'h100, 1,1, 'h14,  'hFFEB,  'h18,  4));
    vecs.push_back(mk(0,1,0,0,     1,1, 'h104, 1,1, 'h100, 'hFEFF,  'h104, 1));
    vecs.push_back(mk(0,1,0,0,     1,1, 'h108, 1,1, 'h104, 'hFEFB,  'h108, 1));
    // redirect with fetch disabled
    vecs.push_back(mk(0,0,1,'h200, 0,1, 'h200, 0,1, 'h108, 'hFEF7,  'h10C, 1));
    vecs.push_back(mk(0,0,0,0,     1,1, 'h200, 0,0, 0,     0,       0,     0));
    vecs.push_back(mk(0,1,0,0,     1,1, 'h200, 1,0, 0,     0,       0,     0));
    vecs.push_back(mk(0,1,0,0,     0,1, 'h204, 1,1, 'h200, 'hFDFF,  'h204, 1));
    vecs.push_back(mk(0,1,0,0,     0,1, 'h208, 1,1, 'h200, 'hFDFF,  'h204, 2));
    // reset wins over a simultaneous redirect
    vecs.push_back(mk(1,1,1,'h300, 0,1, 'h300, 0,1, 'h200, 'hFDFF,  'h204, 3));
    vecs.push_back(mk(0,0,0,0,     1,1, 'h0,   0,0, 0,     0,       0,     0));

    foreach (vecs[k]) begin
      rst = vecs[k].rst; enable = vecs[k].en; redirect = vecs[k].redir;
      redirect_pc = vecs[k].rpc; out_ready = vecs[k].rdy;
      #3;
      if (vecs[k].chk) begin
        chk($sformatf("v%0d imem_addr", k), addr1, vecs[k].addr);
        chk($sformatf("v%0d imem_req", k), 32'(req1), 32'(vecs[k].req));
        chk($sformatf("v%0d out_valid", k), 32'(vld1), 32'(vecs[k].vld));
        chk($sformatf("v%0d count", k), 32'(cnt1), 32'(vecs[k].cnt));
        if (vecs[k].vld) begin
          chk($sformatf("v%0d out_pc", k), pc1, vecs[k].pc);
          chk($sformatf("v%0d out_inst", k), inst1, vecs[k].inst);
          chk($sformatf("v%0d out_incpc", k), inc1, vecs[k].incpc);
        end
      end
      tick();
    end

    // out_ready on an empty queue must not underflow
    enable = 1'b0; out_ready = 1'b1; redirect = 1'b0;
    tick();
    chk("empty ready count", 32'(cnt1), 32'd0);
    chk("empty ready valid", 32'(vld1), 32'd0);

    // RESET_PC near the top of the address space, DEPTH=3 instance
    rst = 1'b1; tick(); rst = 1'b0;
    enable = 1'b1; out_ready = 1'b1;
    #3;
    chk("wrap first addr", addr2, 32'hFFFF_FFFC);
    chk("wrap first req", 32'(req2), 32'd1);
    tick();
    chk("wrap head pc", pc2, 32'hFFFF_FFFC);
    chk("wrap head inst", inst2, 32'hFFFF_0003);
    chk("wrap head incpc", inc2, 32'h0000_0000);
    chk("wrap second addr", addr2, 32'h0000_0000);
    tick();
    chk("wrap next pc", pc2, 32'h0000_0000);
    chk("wrap next incpc", inc2, 32'h0000_0004);

    // fill the 3-entry queue, then drain across the pointer wrap
    out_ready = 1'b0;
    tick();
    tick();
    #3;
    chk("d3 full count", 32'(cnt2), 32'd3);
    chk("d3 full req", 32'(req2), 32'd0);
    chk("d3 full addr", addr2, 32'h0000_000C);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("d3 drain%0d pc", i), pc2, 32'(4 * i));
      chk($sformatf("d3 drain%0d count", i), 32'(cnt2), 32'd3);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Parametrised next-generation instruction fetch stage.
- Holds the fetch PC, drives the combinational-read instruction memory, and buffers fetched {pc, inst, pc+INC} entries in a DEPTH-entry circular queue.
- The queue sits between instruction memory and decode, with a valid/ready handshake to decode and a one-cycle redirect path (branch/jump) that flushes the queue.
- Adds decoupling, back-pressure and flush behaviour on top of the plain PC register + increment.

Parameters:
- ADDR_W, 32, width of PC and instruction addresses
- INST_W, 32, width of instruction word
- DEPTH, 4, number of queue entries (any value >= 2)
- INC, 4, PC increment per fetch
- RESET_PC, 0, fetch PC loaded on reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- enable  in  1  global fetch enable; 0 = no new fetch this cycle
- redirect  in  1  take redirect_pc as this cycle's fetch address and flush queue
- redirect_pc  in  ADDR_W  redirect target
- imem_addr  out  ADDR_W  address to instruction memory (combinational)
- imem_req  out  1  fetch performed this cycle
- imem_rdata  in  INST_W  instruction memory read data, valid same cycle as imem_addr
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_pc  out  ADDR_W  head entry PC
- out_inst  out  INST_W  head entry instruction
- out_incpc  out  ADDR_W  head entry PC + INC
- count  out  clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (rst=1 at edge, highest priority over every other input):
  - fetch_pc <= RESET_PC
  - count <= 0; read and write pointers <= 0
  - out_valid = 0 from the following cycle
- imem_addr = redirect ? redirect_pc : fetch_pc. Combinational, no cycle of latency, matching the old takeLeap bypass.
- deq = out_valid & out_ready. out_valid = (count != 0). Head fields are driven combinationally from the read-pointer entry.
- fetch = enable & (redirect | count < DEPTH | deq). imem_req = fetch & ~rst.
- On fetch:
  - push {imem_addr, imem_rdata, imem_addr+INC}
  - fetch_pc <= imem_addr + INC
- PC arithmetic is modulo 2^ADDR_W: wrap-around from all-ones + INC is silent.
- No fetch, no redirect: fetch_pc holds.
- Redirect:
  - Any deq in the same cycle completes; decode consumed the old head.
  - All other entries are discarded: pointers reset to 0, count <= (fetch ? 1 : 0).
  - If enable=1, the entry at redirect_pc is written in the same cycle and appears as head next cycle.
  - If enable=0, fetch_pc <= redirect_pc and no entry is written.
- Full (count = DEPTH):
  - With deq in the same cycle: push and pop occur together, count unchanged.
  - Without deq and without redirect: no fetch, imem_req=0, fetch_pc holds.
- Empty: out_valid=0 and out_ready is ignored. An entry pushed this cycle is visible at the head next cycle; there is no same-cycle bypass.
- Count update (no redirect): count <= count + fetch − deq.
- Pointers increment and wrap DEPTH−1 -> 0. DEPTH need not be a power of two.
- Head fields while out_valid=0 are don't-care.
- Reset mid-operation discards all entries. A redirect asserted with rst is ignored.

Test Plan:
- Reset then enable=1, out_ready=1, imem returns addr^0xFFFF -> imem_addr 0,4,8,… each cycle; out_pc lags by 1 cycle; out_inst=0xFFFF,0xFFFB,…; out_incpc=out_pc+4; count stays 1.
- enable=1, out_ready=0 for 6 cycles (DEPTH=4) -> count 1,2,3,4,4,4; imem_req=0 once full; fetch_pc holds 0x10. Then out_ready=1 -> heads 0,4,8,C in order, fetch resumes at 0x10.
- Full queue, redirect=1, redirect_pc=0x100, out_ready=1 -> imem_addr=0x100 that cycle; head 0x0 accepted; next cycle count=1, out_pc=0x100; then 0x104 follows.
- redirect=1 with enable=0, redirect_pc=0x200 -> count=0 next cycle, out_valid=0; on enable=1, imem_addr=0x200.
- RESET_PC=0xFFFFFFFC -> first fetch 0xFFFFFFFC with out_incpc=0x0, second fetch addr 0x0.
- rst asserted with count=3 and redirect=1 -> next cycle count=0, out_valid=0, imem_addr=RESET_PC.
